onchip_mem_pattern_master: RTL
==============================

// Module: onchip_mem_pattern_master
// PURPOSE
//  Avalon-MM master that writes, then reads back and verifies, a deterministic 128-bit pattern.
//  It targets the single-port on-chip RAM slave (15-bit word address, 16-lane byteenable, fixed read latency).
//  It sits on the same clk domain as the RAM and is used for RAM bring-up and regression checking.
//  Host logic loads a command; the block reports done, an error count and the first failing word address.
// PARAMETERS
//  ADDR_W       15   word-address width of avm_address
//  DATA_W       128  data width; must be a multiple of 32
//  LEN_W        16   width of cmd_len; allows a full 32768-word sweep
//  READ_LATENCY 1    cycles from an accepted read to a valid avm_readdata; must be 1..4
// PORTS
//  clk             in   1       system clock
//  reset_n         in   1       synchronous reset, active low
//  cmd_start       in   1       1-cycle pulse; sampled only in IDLE
//  cmd_mode        in   2       01=write only, 10=read-verify only, 11=write then verify, 00=no-op
//  cmd_base        in   ADDR_W  first word address
//  cmd_len         in   LEN_W   word count
//  cmd_seed        in   32      pattern seed
//  busy            out  1       high from the cycle after an accepted start until done
//  done            out  1       1-cycle pulse at command completion
//  err_count       out  16      verify mismatches; saturates at 0xFFFF
//  err_first_addr  out  ADDR_W  address of the first mismatch
//  err_valid       out  1       err_first_addr is valid
//  avm_address     out  ADDR_W  word address
//  avm_byteenable  out  DATA_W/8  all ones during any transfer
//  avm_chipselect  out  1       high whenever avm_read or avm_write is high
//  avm_write       out  1       write strobe
//  avm_read        out  1       read strobe
//  avm_writedata   out  DATA_W  pattern word
//  avm_readdata    in   DATA_W  read data
//  avm_waitrequest in   1       stall; tie to 0 for the on-chip RAM
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge): state=IDLE; all outputs 0, including err_*; the pipe is flushed.
//   This holds mid-command: no further bus strobe after the reset edge, and no done pulse.
//  Pattern: word i (0-based) = {DATA_W/32{cmd_seed + i}} (mod 2^32). Address i = (cmd_base + i) mod 2^ADDR_W (wraps).
//  FSM: IDLE -> WR -> RD -> DRAIN -> DONE -> IDLE. WR is skipped unless mode[0]; RD/DRAIN are skipped unless mode[1].
//  IDLE: on cmd_start, latch all cmd_* inputs and clear err_*.
//   If cmd_len==0 or mode==00, go to DONE directly: done pulses 2 cycles after start, with no bus activity.
//  WR: one write per cycle; the transfer is accepted when avm_waitrequest=0.
//   While waitrequest=1, address, data and strobes are held unchanged. Leave after cmd_len accepted writes.
//  RD: one read per cycle on the same hold rules. Each accepted read pushes {addr, expected word} into the pipe.
//   Leave after cmd_len accepted reads. There is no idle cycle between the last WR and the first RD.
//  DRAIN: wait until the pipe is empty (READ_LATENCY cycles after the last accepted read).
//  Compare: when the pipe output is valid, avm_readdata != expected -> err_count++ (saturating).
//   On the first mismatch only: err_first_addr <= addr and err_valid <= 1.
//  DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
//  A cmd_start while busy is ignored. Counters are LEN_W+1 bits wide, so cmd_len=2^LEN_W-1 runs without overflow.
// STRUCTURE
//  Package onchip_mem_pm_pkg: MODE_WR/MODE_RD constants, state enum type, pattern_word() function.
//  Sub-module avm_rd_expect_pipe: a READ_LATENCY-deep shift register of {valid, addr, expected}.
//   Cleared by reset_n; the top level does the compare.
// TESTING (slave model: 32768x128 RAM, latency READ_LATENCY, optional random waitrequest)
//  1 mode=11, base=0x7FFE, len=4, seed=0x10 -> writes to 7FFE,7FFF,0000,0001 with lanes 0x10..0x13;
//    err_count=0, err_valid=0, single done pulse.
//  2 Preload RAM; flip bit 0 of word 0x0005; mode=10, base=0, len=16, seed=0 -> err_count=1, err_first_addr=0x0005.
//  3 Scenario 1 with 50% random waitrequest -> strobes and data held while stalled;
//    exactly 4 writes and 4 reads accepted; err_count=0.
//  4 len=0, mode=11 -> done 2 cycles after start; avm_chipselect never high.
//  5 reset_n=0 during RD of a 100-word command -> next cycle all strobes=0, busy=0, no done pulse;
//    a new command then runs clean.
//  6 cmd_start pulsed while busy -> ignored; READ_LATENCY=3 build passes scenario 2.

Source files
------------

// File: rtl/onchip_mem_pm_pkg.sv
// ---------------------------------------------------------------------------
// onchip_mem_pm_pkg
//   Shared definitions for the on-chip RAM pattern master: command mode
//   encodings, the controller state type and the pattern generator.
//   No ports (package).
// ---------------------------------------------------------------------------
package onchip_mem_pm_pkg;

  // cmd_mode bit meanings; both bits set means write then verify.
  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_WR   = 2'b01;
  localparam logic [1:0] MODE_RD   = 2'b10;

  // Saturation value of the mismatch counter.
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // One 32-bit lane of pattern word idx; the full bus word repeats this lane.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed,
                                               input logic [31:0] idx);
    return seed + idx;
  endfunction

endpackage

// File: rtl/avm_rd_expect_pipe.sv
// ---------------------------------------------------------------------------
// avm_rd_expect_pipe
//   DEPTH-stage shift register carrying {valid, addr, expected word} for each
//   accepted read, so the last stage lines up with avm_readdata exactly
//   DEPTH (= read latency) cycles after the read was accepted.
// Ports
//   clk, reset_n    clock, synchronous active-low reset (clears valid bits)
//   push_i          a read is accepted this cycle
//   push_addr_i     word address of that read
//   push_exp_i      word the read is expected to return
//   valid_o         last stage holds a read whose data is on the bus now
//   addr_o, exp_o   address / expected word of that read
//   pending_o       some read is still travelling in the earlier stages
// ---------------------------------------------------------------------------
module avm_rd_expect_pipe #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_exp_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] exp_o,
  output logic              pending_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] exp_q  [DEPTH];

  // NOTE: clocked state uses non-blocking assignments so every stage samples
  // its predecessor's value from before the edge, giving a true shift.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // NOTE: payload registers are deliberately not reset; they are only ever
  // consumed alongside a valid bit, and the valid bits are reset.
  always_ff @(posedge clk) begin
    addr_q[0] <= push_addr_i;
    exp_q[0]  <= push_exp_i;
    for (int i = 1; i < DEPTH; i++) begin
      addr_q[i] <= addr_q[i-1];
      exp_q[i]  <= exp_q[i-1];
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign addr_o  = addr_q[DEPTH-1];
  assign exp_o   = exp_q[DEPTH-1];

  // The last stage is compared in the current cycle, so only the earlier
  // stages count as outstanding work.
  // NOTE: the output is given a default before the loop so no path through
  // this block leaves it unassigned (which would infer a latch).
  always_comb begin
    pending_o = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending_o = pending_o | valid_q[i];
    end
  end

endmodule

// File: rtl/onchip_mem_pattern_master.sv
// ---------------------------------------------------------------------------
// onchip_mem_pattern_master
//   Avalon-MM master that writes a deterministic pattern to a RAM window and
//   then reads it back and verifies it, reporting mismatches.
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   cmd_start           start pulse, honoured only while idle
//   cmd_mode            01 write, 10 read-verify, 11 both, 00 no-op
//   cmd_base/len/seed   first word address, word count, pattern seed
//   busy, done          command in progress / 1-cycle completion pulse
//   err_count           saturating mismatch count
//   err_first_addr      address of the first mismatch (valid with err_valid)
//   avm_*               Avalon-MM master interface to the RAM
// ---------------------------------------------------------------------------
module onchip_mem_pattern_master
  import onchip_mem_pm_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 128,
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_start,
  input  logic [1:0]          cmd_mode,
  input  logic [ADDR_W-1:0]   cmd_base,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [31:0]         cmd_seed,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_count,
  output logic [ADDR_W-1:0]   err_first_addr,
  output logic                err_valid,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic                avm_read,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  // One bit wider than cmd_len so the largest length never wraps the index.
  localparam logic [LEN_W:0] IDX_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [LEN_W:0]    idx_q, idx_d;
  logic              verify_q, verify_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       seed_q, seed_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       err_count_q, err_count_d;
  logic [ADDR_W-1:0] err_first_addr_q, err_first_addr_d;
  logic              err_valid_q, err_valid_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_word;
  logic              last_xfer;
  logic              rd_accept;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp;
  logic              pipe_pending;

  // Address and data are pure functions of the latched command and the
  // transfer index, so a stall (index not advancing) holds them unchanged.
  assign cur_addr  = base_q + ADDR_W'(idx_q);
  assign cur_word  = {(DATA_W/32){pattern_word(seed_q, 32'(idx_q))}};
  assign last_xfer = ((idx_q + IDX_ONE) == {1'b0, len_q});
  assign rd_accept = (state_q == ST_RD) && !avm_waitrequest;

  assign avm_write      = (state_q == ST_WR);
  assign avm_read       = (state_q == ST_RD);
  assign avm_chipselect = avm_write || avm_read;
  assign avm_byteenable = avm_chipselect ? '1 : '0;
  assign avm_address    = avm_chipselect ? cur_addr : '0;
  assign avm_writedata  = avm_write ? cur_word : '0;

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_count_q;
  assign err_first_addr = err_first_addr_q;
  assign err_valid      = err_valid_q;

  avm_rd_expect_pipe #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (READ_LATENCY)
  ) u_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (rd_accept),
    .push_addr_i (cur_addr),
    .push_exp_i  (cur_word),
    .valid_o     (cmp_valid),
    .addr_o      (cmp_addr),
    .exp_o       (cmp_exp),
    .pending_o   (pipe_pending)
  );

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    verify_d         = verify_q;
    base_d           = base_q;
    len_d            = len_q;
    seed_d           = seed_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    err_count_d      = err_count_q;
    err_first_addr_d = err_first_addr_q;
    err_valid_d      = err_valid_q;

    if (cmp_valid && (avm_readdata != cmp_exp)) begin
      if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + 16'd1;
      end
      if (!err_valid_q) begin
        err_first_addr_d = cmp_addr;
        err_valid_d      = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          base_d           = cmd_base;
          len_d            = cmd_len;
          seed_d           = cmd_seed;
          verify_d         = (cmd_mode & MODE_RD) != MODE_NONE;
          idx_d            = '0;
          busy_d           = 1'b1;
          err_count_d      = '0;
          err_first_addr_d = '0;
          err_valid_d      = 1'b0;
          if (cmd_len == '0 || cmd_mode == MODE_NONE) begin
            state_d = ST_DONE;
          end else if ((cmd_mode & MODE_WR) != MODE_NONE) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (!avm_waitrequest) begin
          if (last_xfer) begin
            idx_d   = '0;
            state_d = verify_q ? ST_RD : ST_DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ST_RD: begin
        if (!avm_waitrequest) begin
          if (last_xfer) begin
            idx_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ST_DRAIN: begin
        // The read in the final stage is compared this cycle, so leave as
        // soon as nothing is left behind it.
        if (!pipe_pending) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      verify_q         <= 1'b0;
      base_q           <= '0;
      len_q            <= '0;
      seed_q           <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_count_q      <= '0;
      err_first_addr_q <= '0;
      err_valid_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      verify_q         <= verify_d;
      base_q           <= base_d;
      len_q            <= len_d;
      seed_q           <= seed_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      err_count_q      <= err_count_d;
      err_first_addr_q <= err_first_addr_d;
      err_valid_q      <= err_valid_d;
    end
  end

endmodule
